// File: rtl/sb_cfg_loader_if.sv
// Configuration byte-stream bundle for a switchbox loader tile: upstream byte
// channel, downstream daisy-chain channel and the commit pulse in/out.
interface sb_cfg_loader_if;
  logic       cfg_in_valid;
  logic [7:0] cfg_in_data;
  logic       cfg_in_ready;
  logic       cfg_commit;
  logic       cfg_out_valid;
  logic [7:0] cfg_out_data;
  logic       cfg_out_ready;
  logic       cfg_commit_out;

  modport master (
    output cfg_in_valid, cfg_in_data, cfg_commit, cfg_out_ready,
    input  cfg_in_ready, cfg_out_valid, cfg_out_data, cfg_commit_out
  );

  modport slave (
    input  cfg_in_valid, cfg_in_data, cfg_commit, cfg_out_ready,
    output cfg_in_ready, cfg_out_valid, cfg_out_data, cfg_commit_out
  );
endinterface

// File: rtl/sb_cfg_loader.sv
// Configuration loader for one Wilton switchbox tile: fills a shadow route_sel
// array from a byte stream, forwards surplus bytes downstream, commits atomically.
module sb_cfg_loader #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  sb_cfg_loader_if.slave             cfg,
  output logic [WIDTH-1:0][3:0][1:0] route_sel_o,
  output logic                       cfg_done_o,
  output logic                       cfg_err_o
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  // COMMIT is the single cycle in which cfg_commit_out is high and the check lands.
  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_PASS   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  state_e                      state_q;
  state_e                      state_d;
  state_e                      drain_tgt_s;
  logic [WIDTH-1:0][7:0]       shadow_q;
  logic [CW-1:0]               count_q;
  logic                        done_q;
  logic                        err_q;
  logic                        out_valid_q;
  logic                        out_valid_d;
  logic [7:0]                  out_data_q;
  logic                        commit_out_q;
  logic [WIDTH-1:0][3:0][1:0]  route_q;
  logic                        in_ready_s;
  logic                        accept_s;
  logic                        load_acc_s;
  logic                        pass_acc_s;
  logic                        legal_s;

  // A wire is legal when at most one of its four direction entries drives it.
  function automatic logic wire_legal(input logic [7:0] b);
    logic [2:0] n;
    n = 3'd0;
    for (int d = 0; d < 4; d++) begin
      if (b[2*d +: 2] != 2'b11) begin
        n = n + 3'd1;
      end
    end
    return (n <= 3'd1);
  endfunction

  function automatic logic shadow_legal(input logic [WIDTH-1:0][7:0] sh);
    logic ok;
    ok = 1'b1;
    for (int w = 0; w < WIDTH; w++) begin
      ok = ok & wire_legal(sh[w]);
    end
    return ok;
  endfunction

  assign accept_s   = cfg.cfg_in_valid & in_ready_s;
  assign load_acc_s = accept_s & (state_q == ST_LOAD);
  assign pass_acc_s = accept_s & (state_q == ST_PASS);
  assign legal_s    = shadow_legal(shadow_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a commit skips DRAIN when the output register empties this cycle
  always_comb begin
    state_d     = state_q;
    drain_tgt_s = out_valid_d ? ST_DRAIN : ST_COMMIT;
    case (state_q)
      ST_LOAD: begin
        if (cfg.cfg_commit) begin
          state_d = drain_tgt_s;
        end else if (load_acc_s && (count_q == LAST_IDX)) begin
          state_d = ST_PASS;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_PASS: begin
        if (cfg.cfg_commit) begin
          state_d = drain_tgt_s;
        end else begin
          state_d = ST_PASS;
        end
      end
      ST_DRAIN: begin
        if (!out_valid_d) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_COMMIT: state_d = ST_LOAD;
      default:   state_d = ST_LOAD;
    endcase
  end

  // Output logic: input handshake, commit always wins over a byte
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      ST_LOAD: in_ready_s = ~cfg.cfg_commit;
      ST_PASS: in_ready_s = ~cfg.cfg_commit & (~out_valid_q | cfg.cfg_out_ready);
      default: in_ready_s = 1'b0;
    endcase
  end

  // Forwarding register occupancy: fill on accept in PASS, empty on downstream ready
  always_comb begin
    out_valid_d = out_valid_q;
    if (pass_acc_s) begin
      out_valid_d = 1'b1;
    end else if (cfg.cfg_out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Shadow fill, forwarding data, commit pulse and checked commit update
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q     <= '1;
      count_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      commit_out_q <= 1'b0;
      route_q      <= '1;
    end else begin
      out_valid_q  <= out_valid_d;
      commit_out_q <= (state_d == ST_COMMIT);
      if (pass_acc_s) begin
        out_data_q <= cfg.cfg_in_data;
      end
      if (load_acc_s) begin
        for (int w = 0; w < WIDTH; w++) begin
          if (count_q == CW'(w)) begin
            shadow_q[w] <= cfg.cfg_in_data;
          end
        end
        count_q <= count_q + CW'(1);
        if (count_q == LAST_IDX) begin
          done_q <= 1'b1;
        end
      end
      // An incomplete load is rejected exactly like an illegal one
      if (state_q == ST_COMMIT) begin
        count_q <= '0;
        done_q  <= 1'b0;
        if ((count_q == FULL_CNT) && legal_s) begin
          route_q <= shadow_q;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign cfg.cfg_in_ready   = in_ready_s;
  assign cfg.cfg_out_valid  = out_valid_q;
  assign cfg.cfg_out_data   = out_data_q;
  assign cfg.cfg_commit_out = commit_out_q;
  assign route_sel_o        = route_q;
  assign cfg_done_o         = done_q;
  assign cfg_err_o          = err_q;
endmodule
